// File: rtl/room_pkg.sv
`default_nettype none
// ============================================================================
// Module      : room_pkg
// Description : Shared types and constants for the room plant model: the
//               thermal state enum, temperature width/limits, reset and
//               ambient defaults, and the single-step temperature update.
// Revision    : 1.0 - initial release
// ============================================================================
package room_pkg;

    // Temperature is a 5-bit unsigned degree count, 0..31.
    localparam int              TEMP_W          = 5;
    localparam logic [TEMP_W-1:0] TEMP_MAX      = 5'd31;
    localparam logic [TEMP_W-1:0] TEMP_MIN      = 5'd0;

    // Power-on temperature and drift target used when the top is not overridden.
    localparam logic [TEMP_W-1:0] T_INIT_DEFAULT  = 5'd20;
    localparam logic [TEMP_W-1:0] AMBIENT_DEFAULT = 5'd15;

    // Width of the cycle prescaler; rates must fit in 1..2**RATE_W.
    localparam int RATE_W = 8;

    // Thermal mode of the room, decoded from the controller commands.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAT  = 2'd1,
        COOL  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Temperature after one rate step in the given mode. Limits are checked
    // before the add/subtract so the 5-bit value never wraps; in IDLE the
    // value moves one degree toward the ambient target and stays put there.
    function automatic logic [TEMP_W-1:0] next_temp(
        input state_t             mode,
        input logic [TEMP_W-1:0]  temp,
        input logic [TEMP_W-1:0]  ambient
    );
        logic [TEMP_W-1:0] result;
        result = temp;
        case (mode)
            HEAT: begin
                if (temp != TEMP_MAX) begin
                    result = temp + 5'd1;
                end
            end
            COOL: begin
                if (temp != TEMP_MIN) begin
                    result = temp - 5'd1;
                end
            end
            IDLE: begin
                if (temp > ambient) begin
                    result = temp - 5'd1;
                end else if (temp < ambient) begin
                    result = temp + 5'd1;
                end
            end
            default: begin
                result = temp;
            end
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/room_model_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : rate_prescaler
// Description : Cycle prescaler for the room model. Counts up from zero and
//               raises a one-cycle terminal-count tick when the count hits
//               the rate of the selected mode minus one, then wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rate_prescaler
    import room_pkg::*;
#(
    parameter int HEAT_RATE  = 8,
    parameter int COOL_RATE  = 8,
    parameter int DRIFT_RATE = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear,
    input  state_t rate_sel,
    output logic   tick
);

    // Terminal counts: a rate of R ticks on every R-th cycle.
    localparam logic [RATE_W-1:0] c_heat_tc  = RATE_W'(HEAT_RATE - 1);
    localparam logic [RATE_W-1:0] c_cool_tc  = RATE_W'(COOL_RATE - 1);
    localparam logic [RATE_W-1:0] c_drift_tc = RATE_W'(DRIFT_RATE - 1);

    logic [RATE_W-1:0] r_count;
    logic [RATE_W-1:0] w_tc;
    logic              w_at_tc;

    // Select the terminal count that belongs to the current mode.
    always_comb begin
        w_tc = c_drift_tc;
        case (rate_sel)
            HEAT:    w_tc = c_heat_tc;
            COOL:    w_tc = c_cool_tc;
            IDLE:    w_tc = c_drift_tc;
            default: w_tc = c_drift_tc;
        endcase
    end

    assign w_at_tc = (r_count == w_tc);

    // A clear in the same cycle as terminal count wins: a partial or just
    // completed interval never produces a step once the mode or value moves.
    assign tick = w_at_tc && !clear;

    // Count up, wrapping at terminal count and restarting on clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || w_at_tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/room_model.sv
`default_nettype none
// ============================================================================
// Module      : room_model
// Description : Behavioural room plant for the air-conditioning controller.
//               Decodes heat/cool commands into a thermal mode, moves the
//               5-bit temperature one degree per rate interval (saturating),
//               drifts toward ambient when idle and flags contradictory
//               commands as a fault. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module room_model
    import room_pkg::*;
#(
    parameter int                HEAT_RATE  = 8,
    parameter int                COOL_RATE  = 8,
    parameter int                DRIFT_RATE = 32,
    parameter logic [TEMP_W-1:0] T_INIT     = T_INIT_DEFAULT,
    parameter logic [TEMP_W-1:0] AMBIENT    = AMBIENT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              heating,
    input  logic              cooling,
    input  logic              load_en,
    input  logic [TEMP_W-1:0] load_val,
    output logic [TEMP_W-1:0] temperature,
    output logic              step,
    output logic              fault
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_state_change;
    logic              w_clear;
    logic              w_tick;
    logic [TEMP_W-1:0] r_temp;
    logic [TEMP_W-1:0] w_step_temp;
    logic              w_do_step;
    logic              r_step;
    logic              r_fault;

    // Decode the next thermal mode from the commands. Once in FAULT the
    // model only leaves when both commands have been released.
    always_comb begin
        w_next_state = IDLE;
        if (r_state == FAULT && (heating || cooling)) begin
            w_next_state = FAULT;
        end else if (heating && cooling) begin
            w_next_state = FAULT;
        end else if (heating) begin
            w_next_state = HEAT;
        end else if (cooling) begin
            w_next_state = COOL;
        end else begin
            w_next_state = IDLE;
        end
    end

    assign w_state_change = (w_next_state != r_state);

    // The prescaler restarts on any mode change or forced load and is held
    // at zero for the whole time the model sits in FAULT.
    assign w_clear = w_state_change || load_en || (r_state == FAULT);

    rate_prescaler #(
        .HEAT_RATE  (HEAT_RATE),
        .COOL_RATE  (COOL_RATE),
        .DRIFT_RATE (DRIFT_RATE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .rate_sel (r_state),
        .tick     (w_tick)
    );

    // Candidate value for a rate step; a step only counts if it moves the
    // temperature, so saturation and sitting at ambient give no pulse.
    assign w_step_temp = next_temp(r_state, r_temp, AMBIENT);
    assign w_do_step   = w_tick && (w_step_temp != r_temp);

    // Mode register, saturating temperature register and registered
    // step/fault flags. A forced load overrides any step in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_temp  <= T_INIT;
            r_step  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_fault <= (w_next_state == FAULT);
            if (load_en) begin
                r_temp <= load_val;
                r_step <= 1'b0;
            end else if (w_do_step) begin
                r_temp <= w_step_temp;
                r_step <= 1'b1;
            end else begin
                r_step <= 1'b0;
            end
        end
    end

    assign temperature = r_temp;
    assign step        = r_step;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_room_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_room_model
// Description : Self-checking bench for room_model. A cycle-level reference
//               model (mode age counted in cycles, integer arithmetic) is
//               stepped on every clock edge and compared with the DUT; the
//               directed scenarios add end-of-phase checks, followed by a
//               randomised command/load/reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_room_model;

    localparam int C_HEAT    = 8;
    localparam int C_COOL    = 8;
    localparam int C_DRIFT   = 32;
    localparam int C_T_INIT  = 20;
    localparam int C_AMBIENT = 15;

    logic       clk;
    logic       rst_n;
    logic       heating;
    logic       cooling;
    logic       load_en;
    logic [4:0] load_val;
    logic [4:0] temperature;
    logic       step;
    logic       fault;

    int n_cmp;
    int n_err;
    int n_cyc;
    int step_cnt;
    int last_step_cyc;

    // Reference model: mode 0 idle, 1 heat, 2 cool, 3 fault; age counts
    // cycles spent in the mode since entry or since the last load.
    int m_mode;
    int m_age;
    int m_temp;
    int m_step;
    int m_fault;

    room_model #(
        .HEAT_RATE  (C_HEAT),
        .COOL_RATE  (C_COOL),
        .DRIFT_RATE (C_DRIFT),
        .T_INIT     (5'(C_T_INIT)),
        .AMBIENT    (5'(C_AMBIENT))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .heating     (heating),
        .cooling     (cooling),
        .load_en     (load_en),
        .load_val    (load_val),
        .temperature (temperature),
        .step        (step),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, n_cyc, obs, exp);
        end
    endtask

    function automatic int rate_of(input int mode);
        case (mode)
            1:       return C_HEAT;
            2:       return C_COOL;
            default: return C_DRIFT;
        endcase
    endfunction

    // Advance the reference model by one clock edge using the sampled inputs.
    task automatic model_edge();
        int want;
        int fire;
        int nt;
        if (!rst_n) begin
            m_temp  = C_T_INIT;
            m_mode  = 0;
            m_age   = 0;
            m_step  = 0;
            m_fault = 0;
            return;
        end
        if (m_mode == 3 && (heating || cooling)) want = 3;
        else if (heating && cooling)             want = 3;
        else if (heating)                        want = 1;
        else if (cooling)                        want = 2;
        else                                     want = 0;
        fire = 0;
        if (want != m_mode) begin
            m_mode = want;
            m_age  = 0;
        end else if (m_mode == 3) begin
            m_age = 0;
        end else begin
            m_age = m_age + 1;
            fire  = ((m_age % rate_of(m_mode)) == 0) ? 1 : 0;
        end
        nt = m_temp;
        if (load_en) begin
            m_age = 0;
            nt    = int'(load_val);
        end else if (fire == 1) begin
            case (m_mode)
                1: nt = (m_temp + 1 > 31) ? 31 : m_temp + 1;
                2: nt = (m_temp - 1 < 0) ? 0 : m_temp - 1;
                default: begin
                    if (m_temp > C_AMBIENT)      nt = m_temp - 1;
                    else if (m_temp < C_AMBIENT) nt = m_temp + 1;
                end
            endcase
        end
        m_step  = (!load_en && nt != m_temp) ? 1 : 0;
        m_temp  = nt;
        m_fault = (m_mode == 3) ? 1 : 0;
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
        n_cyc++;
        if (step) begin
            step_cnt++;
            last_step_cyc = n_cyc;
        end
        check("temperature", int'(temperature), m_temp);
        check("step", int'(step), m_step);
        check("fault", int'(fault), m_fault);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_load(input int val);
        load_en  = 1'b1;
        load_val = 5'(val);
        run_cycle();
        load_en  = 1'b0;
    endtask

    initial begin
        int prev_step;
        int gap_bad;
        int wait_cyc;
        n_cmp = 0; n_err = 0; n_cyc = 0; step_cnt = 0; last_step_cyc = 0;
        m_mode = 0; m_age = 0; m_temp = C_T_INIT; m_step = 0; m_fault = 0;
        rst_n = 1'b0; heating = 1'b0; cooling = 1'b0; load_en = 1'b0; load_val = '0;
        run_n(2);
        rst_n = 1'b1;
        check("reset_temp", int'(temperature), 20);
        check("reset_step", int'(step), 0);
        check("reset_fault", int'(fault), 0);

        // Continuous heating: mode entry edge plus five 8-cycle intervals.
        heating = 1'b1; step_cnt = 0; prev_step = 0; gap_bad = 0;
        for (int i = 0; i < 41; i++) begin
            run_cycle();
            if (step) begin
                if (prev_step != 0 && n_cyc - prev_step != 8) gap_bad++;
                prev_step = n_cyc;
            end
        end
        check("heat_steps", step_cnt, 5);
        check("heat_gap_errors", gap_bad, 0);
        check("heat_temp", int'(temperature), 25);

        // Heat saturation at 31.
        do_load(30);
        step_cnt = 0;
        run_n(40);
        check("heat_sat_temp", int'(temperature), 31);
        check("heat_sat_steps", step_cnt, 1);

        // Cool saturation at 0 (load coincides with the mode change).
        heating = 1'b0; cooling = 1'b1;
        do_load(1);
        step_cnt = 0;
        run_n(24);
        check("cool_sat_temp", int'(temperature), 0);
        check("cool_sat_steps", step_cnt, 1);

        // Idle drift down from 20 to ambient, then quiet, then up from 10.
        cooling = 1'b0; rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1; step_cnt = 0;
        run_n(160);
        check("drift_down_temp", int'(temperature), 15);
        check("drift_down_steps", step_cnt, 5);
        step_cnt = 0;
        run_n(100);
        check("ambient_quiet_steps", step_cnt, 0);
        do_load(10);
        run_n(160);
        check("drift_up_temp", int'(temperature), 15);

        // Fault entry, sticky while any command is high, exit to idle.
        heating = 1'b1; cooling = 1'b1;
        run_cycle();
        check("fault_set", int'(fault), 1);
        run_n(10);
        check("fault_temp_frozen", int'(temperature), 15);
        cooling = 1'b0;
        run_n(5);
        check("fault_sticky", int'(fault), 1);
        heating = 1'b0;
        run_cycle();
        check("fault_clear", int'(fault), 0);

        // Fast toggling never lets a step complete.
        do_load(20);
        step_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            heating = ~heating;
            run_n(4);
        end
        heating = 1'b0;
        check("toggle_steps", step_cnt, 0);
        check("toggle_temp", int'(temperature), 20);

        // Reset mid-count (count 5) together with a load: reset wins and the
        // next heat step needs mode entry plus a full interval.
        run_cycle();
        heating = 1'b1;
        run_n(6);
        rst_n = 1'b0; load_en = 1'b1; load_val = 5'd3;
        run_cycle();
        rst_n = 1'b1; load_en = 1'b0;
        check("reset_wins_temp", int'(temperature), 20);
        check("reset_wins_fault", int'(fault), 0);
        step_cnt = 0; wait_cyc = 0;
        for (int i = 0; i < 20 && step_cnt == 0; i++) begin
            run_cycle();
            wait_cyc++;
        end
        check("post_reset_first_step", wait_cyc, 9);
        check("post_reset_temp", int'(temperature), 21);

        // Randomised commands, loads and occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            int cmd;
            int len;
            cmd = int'($urandom_range(0, 9));
            heating = (cmd <= 2 || cmd == 9);
            cooling = ((cmd >= 3 && cmd <= 5) || cmd == 9);
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                load_en  = ($urandom_range(0, 49) == 0);
                load_val = 5'($urandom_range(0, 31));
                rst_n    = ($urandom_range(0, 299) != 0);
                run_cycle();
            end
        end
        rst_n = 1'b1; load_en = 1'b0; heating = 1'b0; cooling = 1'b0;
        run_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
